// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one serial binary-to-BCD converter among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining BCD_ARB_TIMEOUT_EN.
module bcd_conv_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned BIN_W          = 32,
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ-1:0][BIN_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]                req_ack,
  output logic [BIN_W-1:0]                  conv_binary,
  output logic                              conv_load,
  input  logic [NUM_DIGITS*4-1:0]           conv_bcd,
  input  logic                              conv_done,
  output logic                              rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
  output logic [NUM_DIGITS*4-1:0]           rsp_bcd,
  output logic                              rsp_err
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic [ID_W-1:0]         id_q, id_d;
  logic [BIN_W-1:0]        bin_q, bin_d;
  logic [ID_W-1:0]         rsp_id_q, rsp_id_d;
  logic [NUM_DIGITS*4-1:0] rsp_bcd_q, rsp_bcd_d;

`ifdef BCD_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Round-robin search: first set req bit starting just above the pointer, wrapping.
  logic            found;
  logic [ID_W-1:0] pick;
  logic [ID_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    bin_d     = bin_q;
    rsp_id_d  = rsp_id_q;
    rsp_bcd_d = rsp_bcd_q;
`ifdef BCD_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          id_d    = pick;
          bin_d   = req_data[pick];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        ptr_d   = id_q;
        state_d = S_ARM;
      end
      S_ARM: begin
        // conv_done is deliberately ignored here: it may still be high from the last job.
`ifdef BCD_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (conv_done) begin
          rsp_bcd_d = conv_bcd;
          rsp_id_d  = id_q;
`ifdef BCD_ARB_TIMEOUT_EN
          err_d     = 1'b0;
`endif
          state_d   = S_RESP;
        end
`ifdef BCD_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_bcd_d = '0;
          rsp_id_d  = id_q;
          err_d     = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= ID_W'(NUM_REQ - 1);
      id_q      <= '0;
      bin_q     <= '0;
      rsp_id_q  <= '0;
      rsp_bcd_q <= '0;
`ifdef BCD_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      bin_q     <= bin_d;
      rsp_id_q  <= rsp_id_d;
      rsp_bcd_q <= rsp_bcd_d;
`ifdef BCD_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    req_ack = '0;
    if (state_q == S_LOAD) req_ack[id_q] = 1'b1;
  end

  assign conv_load   = (state_q == S_LOAD);
  assign conv_binary = bin_q;
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_id      = rsp_id_q;
  assign rsp_bcd     = rsp_bcd_q;
`ifdef BCD_ARB_TIMEOUT_EN
  assign rsp_err     = rsp_valid & err_q;
`else
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed self-checking bench for bcd_conv_arbiter (default build, watchdog disabled).
module tb_bcd_conv_arbiter;

  logic              clk;
  logic              rst;
  logic [3:0]        req;
  logic [3:0][31:0]  req_data;
  logic [3:0]        req_ack;
  logic [31:0]       conv_binary;
  logic              conv_load;
  logic [15:0]       conv_bcd;
  logic              conv_done;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [15:0]       rsp_bcd;
  logic              rsp_err;

  int tests = 0;
  int fails = 0;

  bcd_conv_arbiter #(
    .NUM_REQ(4),
    .BIN_W(32),
    .NUM_DIGITS(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .req_ack(req_ack),
    .conv_binary(conv_binary),
    .conv_load(conv_load),
    .conv_bcd(conv_bcd),
    .conv_done(conv_done),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_bcd(rsp_bcd),
    .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction that the arbiter is about to grant on the next edge.
  task automatic serve(input int id, input logic [31:0] exp_bin, input logic [15:0] bcd,
                       input int wait_cycles, input logic stale, input logic [3:0] drop);
    logic [3:0] exp_ack;
    exp_ack = '0;
    exp_ack[id] = 1'b1;
    tick();
    tests++;
    if (req_ack !== exp_ack) begin fails++; $error("FAIL load_ack: observed %0h, expected %0h", req_ack, exp_ack); end
    tests++;
    if (conv_load !== 1'b1) begin fails++; $error("FAIL load_pulse: observed %0h, expected 1", conv_load); end
    tests++;
    if (conv_binary !== exp_bin) begin fails++; $error("FAIL load_binary: observed %0h, expected %0h", conv_binary, exp_bin); end
    req = req & ~drop;
    if (stale) conv_done = 1'b1;
    tick();
    tests++;
    if (req_ack !== 4'b0000) begin fails++; $error("FAIL arm_ack: observed %0h, expected 0", req_ack); end
    tests++;
    if (conv_load !== 1'b0) begin fails++; $error("FAIL arm_load: observed %0h, expected 0", conv_load); end
    tests++;
    if (conv_binary !== exp_bin) begin fails++; $error("FAIL arm_binary: observed %0h, expected %0h", conv_binary, exp_bin); end
    tests++;
    if (rsp_valid !== 1'b0) begin fails++; $error("FAIL arm_valid: observed %0h, expected 0", rsp_valid); end
    conv_done = 1'b0;
    tick();
    tests++;
    if (rsp_valid !== 1'b0) begin fails++; $error("FAIL wait_valid: observed %0h, expected 0", rsp_valid); end
    for (int k = 0; k < wait_cycles; k++) begin
      tick();
      tests++;
      if (rsp_valid !== 1'b0) begin fails++; $error("FAIL wait_valid_n: observed %0h, expected 0", rsp_valid); end
    end
    conv_bcd  = bcd;
    conv_done = 1'b1;
    tick();
    tests++;
    if (rsp_valid !== 1'b1) begin fails++; $error("FAIL resp_valid: observed %0h, expected 1", rsp_valid); end
    tests++;
    if (rsp_id !== 2'(id)) begin fails++; $error("FAIL resp_id: observed %0h, expected %0h", rsp_id, id); end
    tests++;
    if (rsp_bcd !== bcd) begin fails++; $error("FAIL resp_bcd: observed %0h, expected %0h", rsp_bcd, bcd); end
    tests++;
    if (rsp_err !== 1'b0) begin fails++; $error("FAIL resp_err: observed %0h, expected 0", rsp_err); end
    conv_done = 1'b0;
    conv_bcd  = 16'hDEAD;
    tick();
    tests++;
    if (rsp_valid !== 1'b0) begin fails++; $error("FAIL post_valid: observed %0h, expected 0", rsp_valid); end
    tests++;
    if (rsp_bcd !== bcd) begin fails++; $error("FAIL post_bcd_hold: observed %0h, expected %0h", rsp_bcd, bcd); end
  endtask

  task automatic check_zero_outputs(input string tag);
    tests++;
    if (req_ack !== 4'b0000) begin fails++; $error("FAIL %s_ack: observed %0h, expected 0", tag, req_ack); end
    tests++;
    if (conv_load !== 1'b0) begin fails++; $error("FAIL %s_load: observed %0h, expected 0", tag, conv_load); end
    tests++;
    if (conv_binary !== 32'h0) begin fails++; $error("FAIL %s_binary: observed %0h, expected 0", tag, conv_binary); end
    tests++;
    if (rsp_valid !== 1'b0) begin fails++; $error("FAIL %s_valid: observed %0h, expected 0", tag, rsp_valid); end
    tests++;
    if (rsp_id !== 2'd0) begin fails++; $error("FAIL %s_id: observed %0h, expected 0", tag, rsp_id); end
    tests++;
    if (rsp_bcd !== 16'h0) begin fails++; $error("FAIL %s_bcd: observed %0h, expected 0", tag, rsp_bcd); end
    tests++;
    if (rsp_err !== 1'b0) begin fails++; $error("FAIL %s_err: observed %0h, expected 0", tag, rsp_err); end
  endtask

  initial begin
    int vcount;
    rst       = 1'b1;
    req       = '0;
    req_data  = '0;
    conv_bcd  = '0;
    conv_done = 1'b0;
    #1 rst = 1'b0;
    #2;
    check_zero_outputs("rst");
    tick();
    tick();
    rst = 1'b1;
    tick();

    req_data[0] = 32'h22B8;
    req = 4'b0001;
    serve(0, 32'h22B8, 16'h8888, 2, 1'b0, 4'b0001);

    req_data[1] = 32'h1234;
    req = 4'b0010;
    serve(1, 32'h1234, 16'h4660, 10, 1'b1, 4'b0010);

    req_data[3] = 32'd99;
    req = 4'b1000;
    serve(3, 32'd99, 16'h0099, 0, 1'b0, 4'b1000);
    req_data[0] = 32'd7;
    req = 4'b1001;
    serve(0, 32'd7, 16'h0007, 1, 1'b0, 4'b0000);
    serve(3, 32'd99, 16'h0099, 0, 1'b0, 4'b1001);

    for (int i = 0; i < 4; i++) req_data[i] = 32'(10 * i + 5);
    req = 4'b1111;
    serve(0, 32'd5,  16'h0005, 0, 1'b0, 4'b0000);
    serve(1, 32'd15, 16'h0015, 1, 1'b0, 4'b0000);
    serve(2, 32'd25, 16'h0025, 0, 1'b0, 4'b0000);
    serve(3, 32'd35, 16'h0035, 2, 1'b0, 4'b0000);
    serve(0, 32'd5,  16'h0005, 0, 1'b0, 4'b1111);

    req_data[2] = 32'h99;
    req = 4'b0100;
    tick();
    tests++;
    if (req_ack !== 4'b0100) begin fails++; $error("FAIL rw_ack: observed %0h, expected 4", req_ack); end
    req = '0;
    tick();
    tick();
    vcount = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (rsp_valid) vcount++;
    end
    tests++;
    if (vcount !== 0) begin fails++; $error("FAIL rw_no_done_no_resp: observed %0d, expected 0", vcount); end
    tests++;
    if (rsp_err !== 1'b0) begin fails++; $error("FAIL rw_err_low: observed %0h, expected 0", rsp_err); end
    #1 rst = 1'b0;
    #1;
    check_zero_outputs("mid_rst");
    tick();
    rst = 1'b1;
    conv_done = 1'b1;
    vcount = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (rsp_valid || conv_load) vcount++;
    end
    tests++;
    if (vcount !== 0) begin fails++; $error("FAIL post_rst_idle: observed %0d, expected 0", vcount); end
    conv_done = 1'b0;
    req_data[0] = 32'd42;
    req_data[2] = 32'd1;
    req_data[3] = 32'd2;
    req = 4'b1101;
    serve(0, 32'd42, 16'h0042, 1, 1'b0, 4'b1101);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL timeout: simulation did not finish, observed running, expected done");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "bench time limit");
  end

endmodule
